// File: rtl/imdct_window_apply.sv
`default_nettype none
// ============================================================================
// Module   : imdct_window_apply
// Purpose  : Multiplies IMDCT output samples by sine-window ROM coefficients,
//            rounding half-up and saturating to the sample width.
// Revision : 1.0 - initial release
// ============================================================================
module imdct_window_apply #(
    parameter int SAMPLE_W = 24,
    parameter int COEF_W   = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 block_type,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic                       out_last,
    output logic                       rom_enable,
    output logic [1:0]                 rom_window,
    output logic [5:0]                 rom_n,
    input  logic signed [COEF_W-1:0]   rom_data
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_MUL  = 2'd2;
    localparam logic [1:0] c_ST_OUT  = 2'd3;

    localparam int c_PROD_W = SAMPLE_W + COEF_W;
    localparam int c_FRAC   = COEF_W - 1;

    localparam logic signed [c_PROD_W-1:0] c_HALF =
        {{(c_PROD_W-c_FRAC){1'b0}}, 1'b1, {(c_FRAC-1){1'b0}}};
    localparam logic signed [c_PROD_W-1:0] c_MAX =
        {{(c_PROD_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [c_PROD_W-1:0] c_MIN = ~c_MAX;

    logic [1:0]                 r_state;
    logic [1:0]                 w_next;
    logic [1:0]                 r_type;
    logic [5:0]                 r_n;
    logic signed [SAMPLE_W-1:0] r_samp;
    logic signed [SAMPLE_W-1:0] r_out;
    logic                       r_last;
    logic [5:0]                 w_last_idx;

    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_sum;
    logic signed [c_PROD_W-1:0] w_rnd;
    logic signed [SAMPLE_W-1:0] w_sat;

    logic w_busy;
    logic w_in_ready;
    logic w_out_valid;

    // Short windows cover 12 samples, every other type covers 36.
    assign w_last_idx = (r_type == 2'd2) ? 6'd11 : 6'd35;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start)     w_next = c_ST_LOAD;
            c_ST_LOAD: if (in_valid)  w_next = c_ST_MUL;
            c_ST_MUL:                 w_next = c_ST_OUT;
            c_ST_OUT: begin
                if (out_ready) begin
                    w_next = r_last ? c_ST_IDLE : c_ST_LOAD;
                end
            end
            default:                  w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: ;
            c_ST_LOAD: begin
                w_busy     = 1'b1;
                w_in_ready = 1'b1;
            end
            c_ST_MUL:  w_busy = 1'b1;
            c_ST_OUT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // rom_data arrives in MUL, one cycle after the read strobe in LOAD.
    always_comb begin
        w_prod = c_PROD_W'(r_samp) * c_PROD_W'(rom_data);
        w_sum  = w_prod + c_HALF;
        w_rnd  = w_sum >>> c_FRAC;
        if (w_rnd > c_MAX) begin
            w_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (w_rnd < c_MIN) begin
            w_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end else begin
            w_sat = w_rnd[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_type <= 2'd0;
            r_n    <= 6'd0;
            r_samp <= '0;
            r_out  <= '0;
            r_last <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_type <= block_type;
                        r_n    <= 6'd0;
                    end
                end
                c_ST_LOAD: begin
                    if (in_valid) begin
                        r_samp <= in_sample;
                    end
                end
                c_ST_MUL: begin
                    r_out  <= w_sat;
                    r_last <= (r_n == w_last_idx);
                end
                c_ST_OUT: begin
                    if (out_ready && !r_last) begin
                        r_n <= r_n + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = w_busy;
    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_sample = r_out;
    assign out_last   = r_last & w_out_valid;
    assign rom_enable = in_valid & w_in_ready;
    assign rom_window = r_type;
    assign rom_n      = r_n;

endmodule
`default_nettype wire

// File: doc/imdct_window_apply.md
# imdct_window_apply

Windowing stage of the IMDCT datapath in the MP3 decoder. Reads sine-window coefficients from the window ROM and multiplies each IMDCT output sample by its coefficient. It accepts samples through a valid/ready handshake, drives the ROM read address `{window, n}`, and emits rounded, saturated windowed samples through a second valid/ready handshake. One pass covers one block: 36 samples for long blocks, 12 for a short-block window.

## Interface
- `SAMPLE_W`, 24: signed sample width, input and output.
- `COEF_W`, 18: signed window-coefficient width, Q1.17.
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that begins a block pass; honoured only in IDLE.
- `block_type` input 2: window type 0 normal, 1 start, 2 short, 3 stop; latched on accepted `start`.
- `busy` output 1: high whenever state ≠ IDLE.
- `in_valid` input 1: input sample valid.
- `in_ready` output 1: high only in LOAD.
- `in_sample` input SAMPLE_W: signed IMDCT sample.
- `out_valid` output 1: high only in OUT.
- `out_ready` input 1: downstream accepts.
- `out_sample` output SAMPLE_W: windowed sample, registered.
- `out_last` output 1: high with `out_valid` on the final sample of the pass.
- `rom_enable` output 1: ROM read strobe.
- `rom_window` output 2: latched `block_type`.
- `rom_n` output 6: coefficient index n.
- `rom_data` input COEF_W: ROM output. Valid the cycle after the edge that samples `rom_enable`.

## Operation
- States: IDLE, LOAD, MUL, OUT.
- IDLE:
  - `start` latches `block_type` into `type_q` and clears `n`.
  - Sets `len` = 12 if `type_q` = 2, else 36.
  - Goes to LOAD.
- LOAD:
  - `in_ready` = 1.
  - `rom_enable` = `in_valid & in_ready`, combinational.
  - On `in_valid`: register `in_sample` into `samp_q`, go to MUL.
- MUL:
  - Compute `prod = samp_q * rom_data` at full width (signed 42 bits).
  - `rnd = (prod + 2^16) >>> 17`, arithmetic shift, round half up.
  - Saturate `rnd` to [-2^23, 2^23-1] and register into `out_sample`.
  - Set `out_last` = (n == len-1). Go to OUT.
- OUT:
  - `out_valid` = 1.
  - On `out_ready` with `out_last`: go to IDLE.
  - On `out_ready` otherwise: n ← n+1, go to LOAD.
  - Without `out_ready`: hold `out_sample` and `out_last` stable.
- `rom_window` = `type_q` and `rom_n` = `n`, driven from registers at all times. Stable throughout LOAD.
- Short blocks: n runs 0..11 only. Three short windows take three `start` passes.
- `start` outside IDLE is ignored; `type_q` and `n` are unchanged.
- n never exceeds `len`-1. There is no wrap; return to IDLE ends the pass.

## Timing
- Reset values:
  - state IDLE, n 0, `type_q` 0.
  - `out_sample` 0, `out_valid` 0, `out_last` 0, `in_ready` 0, `busy` 0.
  - `rom_enable` 0, `rom_window` 0, `rom_n` 0.
- Reset mid-pass: on the next edge the block returns to IDLE with the values above. The partial block is dropped and no further handshake completes.
- Input accepted at edge k. ROM samples the address at edge k. `rom_data` is valid in cycle k+1. `out_valid` rises after edge k+1.
- Latency: 2 cycles from input acceptance to `out_valid`.
- Throughput: 3 cycles per sample when `out_ready` is held high. A 36-sample pass takes 108 cycles from the first LOAD, plus 1 cycle for `start`.
- Back-pressure: any number of OUT stall cycles. `in_ready` stays low during MUL and OUT.
- `start` and final `out_ready` in the same cycle: `start` is ignored (state is OUT). The next `start` is honoured one cycle later, in IDLE.

## Test plan
- Long block, type 0: `start`, then 36 samples of 1000 with ROM model coef 0x10000 (0.5) at all n; `out_ready` tied high.
  - Required: 36 outputs of 500.
  - `rom_n` steps 0..35 with `rom_window` = 0.
  - `out_last` only on output 36.
  - `busy` low 109 cycles after `start`.
- Short block, type 2: `start` with `block_type` = 2.
  - Required: exactly 12 samples accepted, `rom_n` 0..11, `out_last` on the 12th, back to IDLE.
- Rounding, coef 0x10000:
  - Sample 3 → out 2.
  - Sample -3 → out -1.
  - Sample 0 → out 0.
- Saturation: sample -8388608 with coef -131072 (-1.0) → out 8388607.
- Back-pressure: hold `out_ready` low 5 cycles on sample 7.
  - Required: `out_sample` stable during the stall, `in_ready` low, n unchanged.
  - Sample 8 is accepted only after the handshake.
- Reset at sample 20 of a long block, then `start` with type 3.
  - Required: all outputs at reset values one edge after reset.
  - New pass starts at n 0 with `rom_window` = 3.
  - A `start` pulsed mid-pass during the first block is ignored.
